// File: rtl/key_expansion_engine_if.sv
// Handshake bundle between the key schedule engine, its key source and the
// round pipeline. The engine connects through the slave modport; the
// upstream/downstream environment connects through the master modport.
interface key_expansion_engine_if;
  logic         startValid;
  logic         startReady;
  logic [127:0] cipherKey;
  logic         decrypt;
  logic [127:0] roundKey;   // roundKey_t on the round pipeline side
  logic [3:0]   roundNum;
  logic         keyValid;
  logic         keyReady;
  logic         lastKey;

  modport master (
    output startValid, cipherKey, decrypt, keyReady,
    input  startReady, roundKey, roundNum, keyValid, lastKey
  );

  modport slave (
    input  startValid, cipherKey, decrypt, keyReady,
    output startReady, roundKey, roundNum, keyValid, lastKey
  );
endinterface

// File: rtl/key_expansion_engine.sv
// Iterative AES-128 key schedule: accepts a cipher key, expands one round key
// per cycle into an 11-entry store, then streams the round keys forward
// (encrypt) or backward (decrypt) over a valid/ready handshake.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

// Single-byte AES S-box. Computed as the GF(2^8) multiplicative inverse
// (x^254, with 0 mapping to 0) followed by the FIPS-197 affine transform,
// which avoids carrying a 256-entry table.
module key_expansion_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Square-and-multiply over exponent 254 = 8'b1111_1110, then affine map
  always_comb begin
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, din);
    end
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// Only NUM_ROUNDS = 10 (AES-128) is meaningful: the Rcon table and the
// 4-bit index counters are sized for it.
module key_expansion_engine #(
  parameter int NUM_ROUNDS = `NUM_ROUNDS
) (
  input logic                 clock,
  input logic                 reset_n,
  key_expansion_engine_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  logic [1:0]   state;
  logic [3:0]   exp_idx;
  logic [3:0]   out_idx;
  logic         dec_q;
  logic [127:0] work;                  // most recently expanded entry
  logic [127:0] store [0:NUM_ROUNDS];

  logic [3:0][7:0] rot_w;
  logic [3:0][7:0] sub_w;
  logic [127:0]    next_key;
  logic            key_valid;
  logic            last_key;
  logic            xfer;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // RotWord of w3 feeds the four SubWord lanes
  assign rot_w = {work[23:0], work[31:24]};

  key_expansion_sbox u_sbox [3:0] (
    .din  (rot_w),
    .dout (sub_w)
  );

  // One FIPS-197 word-group step: entry exp_idx from entry exp_idx-1
  always_comb begin
    logic [31:0] temp;
    logic [31:0] w0n;
    logic [31:0] w1n;
    logic [31:0] w2n;
    logic [31:0] w3n;
    temp     = sub_w ^ {rcon(exp_idx), 24'h000000};
    w0n      = work[127:96] ^ temp;
    w1n      = work[95:64]  ^ w0n;
    w2n      = work[63:32]  ^ w1n;
    w3n      = work[31:0]   ^ w2n;
    next_key = {w0n, w1n, w2n, w3n};
  end

  assign key_valid = (state == STREAM);
  assign last_key  = key_valid && (dec_q ? (out_idx == 4'd0) : (out_idx == LAST_IDX));
  assign xfer      = key_valid && bus.keyReady;

  assign bus.startReady = (state == IDLE);
  assign bus.keyValid   = key_valid;
  assign bus.lastKey    = last_key;
  assign bus.roundKey   = key_valid ? store[out_idx] : 128'h0;
  assign bus.roundNum   = key_valid ? out_idx : 4'd0;

  // Control FSM: accept, expand NUM_ROUNDS entries, stream, back to idle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      exp_idx <= 4'd0;
      out_idx <= 4'd0;
      dec_q   <= 1'b0;
      work    <= 128'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.startValid) begin
            work    <= bus.cipherKey;
            dec_q   <= bus.decrypt;
            exp_idx <= 4'd1;
            state   <= EXPAND;
          end
        end
        EXPAND: begin
          work    <= next_key;
          exp_idx <= exp_idx + 4'd1;
          if (exp_idx == LAST_IDX) begin
            state   <= STREAM;
            out_idx <= dec_q ? LAST_IDX : 4'd0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last_key)   state   <= IDLE;
            else if (dec_q) out_idx <= out_idx - 4'd1;
            else            out_idx <= out_idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Round-key store; contents are don't-care after reset so it is not cleared
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.startValid) store[0] <= bus.cipherKey;
    else if (state == EXPAND)            store[exp_idx] <= next_key;
  end
endmodule

// File: tb/tb_key_expansion_engine.sv
// Scoreboard bench for key_expansion_engine: directed FIPS-197 vectors,
// backpressure, busy starts, mid-operation resets and an AES chain check.
module tb_key_expansion_engine;
  localparam logic [127:0] A1_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] A1_R1  = 128'hA0FAFE1788542CB123A339392A6C7605;
  localparam logic [127:0] A1_R10 = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] C1_R1  = 128'hD6AA74FDD2AF72FADAA678F1D6AB76FE;
  localparam logic [127:0] C1_R10 = 128'h13111D7FE3944A17F307A78B4D2B30C5;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C1_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  typedef struct packed {
    logic [3:0]   num;
    logic [127:0] key;
    logic         last;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  bit   bp_en = 1'b0;

  int errors = 0;
  int checks = 0;

  exp_t         exp_q[$];
  logic [7:0]   tb_sbox [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] sched [11];
  logic [127:0] captured [16];

  key_expansion_engine_if bus ();

  key_expansion_engine #(.NUM_ROUNDS(10)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box by walking generator 3 and its inverse together
  task automatic build_sbox();
    logic [7:0] p = 8'h01;
    logic [7:0] q = 8'h01;
    logic [7:0] x;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      tb_sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    tb_sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_sbox[tb_sbox[i]] = 8'(i);
  endtask

  task automatic tb_expand(input logic [127:0] k);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w3, rot, t, a, b, c, d;
    sched[0] = k;
    for (int r = 1; r <= 10; r++) begin
      w3  = sched[r-1][31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {tb_sbox[rot[31:24]], tb_sbox[rot[23:16]], tb_sbox[rot[15:8]], tb_sbox[rot[7:0]]};
      t   = t ^ {rc, 24'h0};
      a   = sched[r-1][127:96] ^ t;
      b   = sched[r-1][95:64] ^ a;
      c   = sched[r-1][63:32] ^ b;
      d   = w3 ^ c;
      sched[r] = {a, b, c, d};
      rc = xt(rc);
    end
  endtask

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0]   cf [4];
    logic [7:0]   a [4];
    logic [7:0]   o;
    logic [127:0] r = '0;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
      for (int row = 0; row < 4; row++) begin
        o = 8'h00;
        for (int k = 0; k < 4; k++) o = o ^ gmul(cf[(k - row + 4) % 4], a[k]);
        r[127-8*(4*c+row) -: 8] = o;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s = pt ^ captured[0];
    logic [127:0] t;
    for (int r = 1; r <= 10; r++) begin
      t = '0;
      for (int i = 0; i < 16; i++)
        t[127-8*i -: 8] = tb_sbox[s[127-8*((i%4) + 4*(((i/4) + (i%4)) % 4)) -: 8]];
      if (r != 10) t = mix(t, 1'b0);
      s = t ^ captured[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [127:0] s = ct ^ captured[10];
    logic [127:0] t;
    for (int r = 9; r >= 0; r--) begin
      t = '0;
      for (int i = 0; i < 16; i++)
        t[127-8*((i%4) + 4*(((i/4) + (i%4)) % 4)) -: 8] = inv_sbox[s[127-8*i -: 8]];
      t = t ^ captured[r];
      if (r != 0) t = mix(t, 1'b1);
      s = t;
    end
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start_key(input logic [127:0] k, input logic dec, input bit push);
    int n = 0;
    while (!bus.startReady && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("start_ready_timeout", bus.startReady, 1'b1);
    for (int i = 0; i < 16; i++) captured[i] = '0;
    bus.startValid = 1'b1;
    bus.cipherKey  = k;
    bus.decrypt    = dec;
    if (push) begin
      tb_expand(k);
      for (int j = 0; j <= 10; j++) begin
        int idx = dec ? 10 - j : j;
        exp_q.push_back('{num: 4'(idx), key: sched[idx], last: (j == 10)});
      end
    end
    @(posedge clock); #1;
    bus.startValid = 1'b0;
    bus.cipherKey  = {$urandom, $urandom, $urandom, $urandom};
    bus.decrypt    = ~dec;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !bus.startReady) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_timeout", (exp_q.size() == 0) && bus.startReady, 1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.keyValid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("valid_timeout", bus.keyValid, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_startReady"}, bus.startReady, 1'b1);
    chk({tag, "_keyValid"},   bus.keyValid, 1'b0);
    chk({tag, "_lastKey"},    bus.lastKey, 1'b0);
    chk({tag, "_roundKey"},   bus.roundKey, 128'h0);
    chk({tag, "_roundNum"},   bus.roundNum, 4'd0);
  endtask

  // Downstream readiness: always ready unless backpressure is enabled
  initial begin
    bus.keyReady = 1'b1;
    forever begin
      @(posedge clock); #1;
      bus.keyReady = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each transfer, checks stall stability
  initial begin
    bit           stalled = 1'b0;
    logic [127:0] h_key = '0;
    logic [3:0]   h_num = '0;
    logic         h_last = 1'b0;
    exp_t         e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", bus.keyValid, 1'b1);
          chk("stall_key",   bus.roundKey, h_key);
          chk("stall_num",   bus.roundNum, h_num);
          chk("stall_last",  bus.lastKey, h_last);
        end
        if (bus.keyValid && bus.keyReady) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_xfer_num", bus.roundNum, 4'hf);
          end else begin
            e = exp_q.pop_front();
            chk("sb_num",  bus.roundNum, e.num);
            chk("sb_key",  bus.roundKey, e.key);
            chk("sb_last", bus.lastKey, e.last);
            captured[bus.roundNum] = bus.roundKey;
          end
        end
        stalled = bus.keyValid && !bus.keyReady;
        h_key   = bus.roundKey;
        h_num   = bus.roundNum;
        h_last  = bus.lastKey;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [127:0] ct;
    build_sbox();
    bus.startValid = 1'b0;
    bus.cipherKey  = '0;
    bus.decrypt    = 1'b0;
    reset_n        = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("por");
    reset_n = 1'b1;
    @(posedge clock); #1;

    // A.1 encrypt, full throughput, latency and back-to-back streaming
    start_key(A1_KEY, 1'b0, 1'b1);
    n = 0;
    @(negedge clock);
    while (!bus.keyValid && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk("expand_cycles", 128'(n), 128'd10);
    n = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (bus.keyValid) n++;
    end
    chk("consecutive_keys", 128'(n), 128'd11);
    @(negedge clock);
    chk("ready_after_last", {bus.startReady, bus.keyValid}, 2'b10);
    @(posedge clock); #1;
    wait_idle(100);
    chk("a1_round0",  captured[0], A1_KEY);
    chk("a1_round1",  captured[1], A1_R1);
    chk("a1_round10", captured[10], A1_R10);

    // C.1 decrypt, descending order
    start_key(C1_KEY, 1'b1, 1'b1);
    wait_idle(100);
    chk("c1_round10", captured[10], C1_R10);
    chk("c1_round1",  captured[1], C1_R1);
    chk("c1_round0",  captured[0], C1_KEY);

    // Pseudo-random backpressure
    bp_en = 1'b1;
    start_key(A1_KEY, 1'b0, 1'b1);
    wait_idle(400);
    bp_en = 1'b0;
    @(posedge clock); #1;

    // Starts while busy are ignored; keys then drive an AES chain
    start_key(C1_KEY, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    bus.startValid = 1'b1;
    bus.cipherKey  = A1_KEY;
    bus.decrypt    = 1'b1;
    @(posedge clock); #1;
    bus.startValid = 1'b0;
    wait_valid();
    @(posedge clock); #1;
    bus.startValid = 1'b1;
    @(posedge clock); #1;
    bus.startValid = 1'b0;
    wait_idle(100);
    repeat (5) @(posedge clock);
    #1;
    chk("busy_no_restart", {bus.startReady, bus.keyValid}, 2'b10);
    ct = aes_enc(C1_PT);
    chk("chain_ciphertext", ct, C1_CT);
    chk("chain_plaintext", aes_dec(ct), C1_PT);

    // Reset while expanding (exp_idx = 5)
    start_key(A1_KEY, 1'b0, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    exp_q.delete();
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk_reset_outputs("rst_expand");

    // Reset while streaming
    start_key(A1_KEY, 1'b0, 1'b1);
    wait_valid();
    repeat (4) @(posedge clock);
    #1;
    exp_q.delete();
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk_reset_outputs("rst_stream");

    // Fresh start after reset
    start_key(A1_KEY, 1'b0, 1'b1);
    wait_idle(100);
    chk("post_rst_round0",  captured[0], A1_KEY);
    chk("post_rst_round1",  captured[1], A1_R1);
    chk("post_rst_round10", captured[10], A1_R10);

    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
